// File: rtl/borrow_select_subtractor_64_seq.sv
// Multi-cycle subtractor: diff = in1 - in2 - bin, one SLICE_W-bit slice per clock.
// Each slice precomputes both borrow-in candidates; a registered borrow picks one.
module borrow_select_subtractor_64_seq #(
   parameter int WIDTH   = 64,
   parameter int SLICE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int NUM_SLICES = WIDTH / SLICE_W;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam int OFF_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_next;
   logic               accept_s;
   logic               last_s;

   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic               borrow_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [OFF_W-1:0]   off_s;
   logic [SLICE_W-1:0] slice_a_s;
   logic [SLICE_W-1:0] slice_b_s;
   logic [SLICE_W:0]   d0_s;
   logic [SLICE_W:0]   d1_s;
   logic [SLICE_W:0]   sel_s;
   logic               ovf_s;

   // Next-state decode and handshake/last-slice strobes.
   always_comb begin
      state_next = state_r;
      accept_s   = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_s   = 1'b1;
               state_next = CALC;
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == LAST_SLICE) begin
               last_s     = 1'b1;
               state_next = DONE;
            end else begin
               state_next = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Slice datapath: both borrow-in candidates, bit SLICE_W of each is its borrow-out.
   always_comb begin
      off_s     = OFF_W'(32'(cnt_r) * SLICE_W);
      slice_a_s = a_r[off_s +: SLICE_W];
      slice_b_s = b_r[off_s +: SLICE_W];
      d0_s      = {1'b0, slice_a_s} - {1'b0, slice_b_s};
      d1_s      = d0_s - {{SLICE_W{1'b0}}, 1'b1};
      if (borrow_r) begin
         sel_s = d1_s;
      end else begin
         sel_s = d0_s;
      end
      ovf_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ sel_s[SLICE_W-1]);
   end

   // State register with registered handshake outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_r   <= state_next;
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
      end
   end

   // Operand capture, borrow chain and slice-by-slice result write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         borrow_r <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
         diff     <= {WIDTH{1'b0}};
         bout     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r      <= in1;
                  b_r      <= in2;
                  borrow_r <= bin;
                  cnt_r    <= {CNT_W{1'b0}};
               end
            end
            CALC: begin
               diff[off_s +: SLICE_W] <= sel_s[SLICE_W-1:0];
               borrow_r               <= sel_s[SLICE_W];
               if (last_s) begin
                  bout  <= sel_s[SLICE_W];
                  ovf   <= ovf_s;
                  cnt_r <= {CNT_W{1'b0}};
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               borrow_r <= borrow_r;
            end
            default: begin
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_borrow_select_subtractor_64_seq.sv
// Self-checking bench: arithmetic reference model, scoreboard queue and directed vectors.
module tb_borrow_select_subtractor_64_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in1;
   logic [63:0] in2;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] diff;
   logic        bout;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [63:0] d;
      logic        b;
      logic        o;
   } res_t;

   res_t exp_q[$];

   borrow_select_subtractor_64_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: unsigned and signed whole-word arithmetic
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
      res_t r;
      logic signed [65:0] s;
      logic signed [65:0] smax;
      logic signed [65:0] smin;
      logic [64:0] need;
      r.d  = a - b - {63'd0, bi};
      need = {1'b0, b} + {64'd0, bi};
      r.b  = ({1'b0, a} < need);
      s    = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bi});
      smax = $signed({2'b00, 1'b0, {63{1'b1}}});
      smin = $signed({2'b11, 1'b1, {63{1'b0}}});
      r.o  = (s > smax) || (s < smin);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard push on accept, pop on result handoff
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) exp_q.push_back(model(in1, in2, bin));
      if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
   end

   // Compare DUT against the model every cycle a result is presented
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            chk("model_diff", diff, exp_q[0].d);
            chk("model_bout", {63'd0, bout}, {63'd0, exp_q[0].b});
            chk("model_ovf", {63'd0, ovf}, {63'd0, exp_q[0].o});
            chk("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
         end
      end
   end

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        input logic [63:0] ed, input logic eb, input logic eo,
                        input int hold, input string name);
      int wait_n;
      int lat;
      @(negedge clk);
      in1 = a; in2 = b; bin = bi; in_valid = 1'b1;
      wait_n = 0;
      while (!in_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      if (!in_ready) begin
         chk({name, "_accept_timeout"}, 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in1 = {$urandom, $urandom};
      in2 = {$urandom, $urandom};
      bin = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk({name, "_latency"}, 64'(lat), 64'd4);
      if (!out_valid) return;
      chk({name, "_diff"}, diff, ed);
      chk({name, "_bout"}, {63'd0, bout}, {63'd0, eb});
      chk({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         in1 = {$urandom, $urandom};
         in2 = {$urandom, $urandom};
         in_valid = 1'b1;
      end
      if (hold > 0) begin
         chk({name, "_diff_after_hold"}, diff, ed);
         chk({name, "_valid_after_hold"}, {63'd0, out_valid}, 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
      chk({name, "_ready_back"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      res_t m;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in1 = 64'd0; in2 = 64'd0; bin = 1'b0;

      m = model(64'd5, 64'd3, 1'b0);
      chk("pin_model_5_3", {m.d[61:0], m.b, m.o}, {62'd2, 1'b0, 1'b0});
      m = model(64'h8000_0000_0000_0000, 64'd1, 1'b0);
      chk("pin_model_ovf", {m.d[61:0], m.b, m.o}, {62'h3FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1});
      m = model(64'd0, 64'd0, 1'b1);
      chk("pin_model_bin", {m.d[61:0], m.b, m.o}, {62'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});

      #23;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_outs", {diff[61:0], bout, ovf}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 0, "sub_5_3");
      do_op(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, "wrap");
      do_op(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, "wrap_bin");
      do_op(64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, "ripple");
      do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, "ovf_neg");
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b1, 1'b1, 0, "ovf_pos");
      do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
            64'h0246_8ACF_1357_9BCE, 1'b0, 1'b0, 10, "backpressure");

      // Abort on the second CALC cycle
      @(negedge clk);
      in1 = 64'hDEAD_BEEF_0000_0001; in2 = 64'h0000_0000_0000_0002; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_outs", {diff[61:0], bout, ovf}, 64'd0);
      chk("abort_diff_hi", {62'd0, diff[63:62]}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (6) @(negedge clk);
      chk("abort_no_result", {63'd0, out_valid}, 64'd0);

      do_op(64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 0, "after_abort");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/borrow_select_subtractor_64_seq.md
Name: borrow_select_subtractor_64_seq

Overview:
Multi-cycle 64-bit subtractor, the inverse-direction companion to the team's combinational carry-select adders. It computes diff = in1 - in2 - bin, processing one SLICE_W-bit slice per clock with carry-select (dual-candidate) slice logic and a registered borrow chain. Operands and results move through valid/ready handshakes, so it can sit in the multiplier/datapath pipelines.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of SLICE_W.
SLICE_W, 16, bits resolved per cycle.
NUM_SLICES, WIDTH/SLICE_W (derived, localparam), cycles per operation.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
in1  input  WIDTH  minuend.
in2  input  WIDTH  subtrahend.
bin  input  1  borrow in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  (in1 - in2 - bin) mod 2^WIDTH.
bout  output  1  borrow out; 1 iff unsigned in1 < in2 + bin.
ovf  output  1  signed overflow of the two's-complement subtraction.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; slice counter=0; captured operands=0.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in1, in2 and bin into internal registers, set borrow register = bin, counter=0, go to CALC. Input values outside the handshake are ignored.
- CALC: in_ready=0. Each cycle, slice k=counter is computed from the registered operands:
  - d0 = a_k - b_k (borrow-in 0) and d1 = a_k - b_k - 1 (borrow-in 1), each SLICE_W bits plus a borrow.
  - The borrow register selects d1/d0 into diff[k*SLICE_W +: SLICE_W] and selects the next borrow.
  - Counter increments. After slice NUM_SLICES-1, the final borrow goes to bout, ovf = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), and the state moves to DONE.
- DONE: out_valid=1. diff, bout and ovf are stable while out_valid=1 and out_ready=0. On out_ready, out_valid drops next cycle and the state returns to IDLE.
- Latency: accept at edge N -> out_valid high after edge N+NUM_SLICES (4 cycles at default). Throughput is one op per NUM_SLICES+2 cycles minimum. There is no back-to-back overlap: in_ready=0 in CALC and DONE.
- diff is written slice by slice during CALC. It is only meaningful while out_valid=1.
- Wrap-around: arithmetic is modulo 2^WIDTH. Example: 0 - 1 gives all-ones, bout=1.
- Reset mid-CALC or mid-DONE: the operation is aborted immediately, all outputs return to reset values, and no result is produced.
- in_valid held high across an op: the next operands are taken only after returning to IDLE, one per handshake.

Test Plan:
- in1=0x0000_0000_0000_0005, in2=0x3, bin=0 -> diff=0x2, bout=0, ovf=0; out_valid rises exactly 4 cycles after accept.
- in1=0, in2=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Also in1=0, in2=0, bin=1 -> same result (borrow-in path).
- Cross-slice borrow ripple: in1=0x0001_0000_0000_0000, in2=0x1 -> diff=0x0000_FFFF_FFFF_FFFF, bout=0.
- Signed overflow: in1=0x8000_0000_0000_0000, in2=0x1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0. Also in1=0x7FFF_FFFF_FFFF_FFFF, in2=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, ovf=1, bout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; operands changed on in1/in2 are ignored. Then release out_ready -> return to IDLE.
- Reset asserted on the 2nd CALC cycle -> out_valid/diff/bout/ovf go to 0 without waiting for a clock edge, and in_ready=1 after release. The next op, 10-3, gives diff=7.
